// File: rtl/alu_operand_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_loader_if
//  Description : Operand-set bus between the operand loader and the 32-bit
//                ALU. The loader drives the registered operand set and its
//                valid flag. The ALU side returns ready.
//                  a_out     [31:0]  operand A, left-justified
//                  b_out     [31:0]  operand B, left-justified
//                  op_out    [2:0]   opcode
//                  unsig_out         unsigned-compare/arith flag
//                  out_valid         operand set valid
//                  out_ready         consumer accepts operand set
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_operand_loader_if;
    logic [31:0] a_out;
    logic [31:0] b_out;
    logic [2:0]  op_out;
    logic        unsig_out;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output a_out,
        output b_out,
        output op_out,
        output unsig_out,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  a_out,
        input  b_out,
        input  op_out,
        input  unsig_out,
        input  out_valid,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/alu_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_loader
//  Description : Sequential front end for the 32-bit ALU. It debounces the
//                three push-buttons and steps through A / B / opcode capture
//                from the switches. It then presents one registered operand
//                set to the ALU with a valid/ready handshake.
//  Ports       : clk, rst        clock, synchronous active-high reset
//                SW[16:0]        switches: [7:0] A, [15:8] B, [2:0] opcode,
//                                [16] unsigned flag
//                KEY[3:1]        raw active-low buttons: 1=load, 2=clear,
//                                3=reissue
//                bus             operand bus (master modport)
//                state_dbg[1:0]  current FSM state
//                have_prev       a transaction completed since reset/clear
//                echo_out[31:0]  display echo (only with OPERAND_ECHO_EN)
//  Options     : `define OPERAND_ECHO_EN adds the registered echo_out port.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PAD_W           = 24
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic [16:0]          SW,
    input  wire logic [3:1]           KEY,
    alu_operand_loader_if.master      bus,
`ifdef OPERAND_ECHO_EN
    output logic [31:0]               echo_out,
`endif
    output logic [1:0]                state_dbg,
    output logic                      have_prev
);

    localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    localparam logic [1:0] c_LOAD_A  = 2'd0;
    localparam logic [1:0] c_LOAD_B  = 2'd1;
    localparam logic [1:0] c_LOAD_OP = 2'd2;
    localparam logic [1:0] c_ISSUE   = 2'd3;

    // w_press[0] = KEY[1] load, [1] = KEY[2] clear, [2] = KEY[3] reissue
    logic [2:0] w_press;

    // ------------------------------------------------------------------
    // Key conditioning: synchroniser, debounce counter, press pulse
    // ------------------------------------------------------------------
    for (genvar g = 0; g < 3; g++) begin : g_key
        logic [1:0]         r_sync;
        logic [1:0]         r_vld;
        logic               r_deb;
        logic               r_armed;
        logic               r_press;
        logic [c_CNT_W-1:0] r_cnt;
        logic               w_differs;
        logic               w_settle;

        assign w_differs = (r_sync[1] != r_deb);
        assign w_settle  = w_differs && (r_cnt == c_CNT_MAX);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync  <= 2'b11;
                r_vld   <= 2'b00;
                r_deb   <= 1'b1;
                r_armed <= 1'b0;
                r_press <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_sync  <= {r_sync[0], KEY[g+1]};
                r_vld   <= {r_vld[0], 1'b1};
                // The synchroniser's reset value is not a real sample, so the
                // key is armed only once a genuine released level has been
                // seen. A key held through reset therefore stays silent
                // until it is released and pressed again.
                if (r_vld[1] && r_sync[1])
                    r_armed <= 1'b1;
                if (w_settle) begin
                    r_deb <= r_sync[1];
                    r_cnt <= '0;
                end else if (w_differs) begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end else begin
                    r_cnt <= '0;
                end
                r_press <= w_settle && !r_sync[1] && r_armed;
            end
        end

        assign w_press[g] = r_press;
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic       w_clear;
    logic       w_cap_a;
    logic       w_cap_b;
    logic       w_cap_op;
    logic       w_reissue;
    logic       w_done;

    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [2:0] r_op;
    logic       r_unsig;
    logic       r_out_valid;
    logic       r_have_prev;

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= c_LOAD_A;
        else
            r_state <= w_next_state;
    end

    // Event decode. Clear masks every other event, and load beats
    // reissue when both buttons land in the same cycle.
    always_comb begin
        w_clear   = w_press[1];
        w_cap_a   = 1'b0;
        w_cap_b   = 1'b0;
        w_cap_op  = 1'b0;
        w_reissue = 1'b0;
        w_done    = 1'b0;
        if (!w_clear) begin
            case (r_state)
                c_LOAD_A: begin
                    w_cap_a   = w_press[0];
                    w_reissue = !w_press[0] && w_press[2] && r_have_prev;
                end
                c_LOAD_B:  w_cap_b  = w_press[0];
                c_LOAD_OP: w_cap_op = w_press[0];
                default:   w_done   = r_out_valid && bus.out_ready;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        if (w_clear)
            w_next_state = c_LOAD_A;
        else if (w_cap_a)
            w_next_state = c_LOAD_B;
        else if (w_reissue)
            w_next_state = c_ISSUE;
        else if (w_cap_b)
            w_next_state = c_LOAD_OP;
        else if (w_cap_op)
            w_next_state = c_ISSUE;
        else if (w_done)
            w_next_state = c_LOAD_A;
    end

    // ------------------------------------------------------------------
    // Operand registers and handshake flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_unsig     <= 1'b0;
            r_out_valid <= 1'b0;
            r_have_prev <= 1'b0;
        end else begin
            if (w_clear) begin
                r_a     <= '0;
                r_b     <= '0;
                r_op    <= '0;
                r_unsig <= 1'b0;
            end else begin
                if (w_cap_a)
                    r_a <= SW[7:0];
                if (w_cap_b)
                    r_b <= SW[15:8];
                if (w_cap_op) begin
                    r_op    <= SW[2:0];
                    r_unsig <= SW[16];
                end
            end
            // Valid tracks the state being entered, so it rises the cycle
            // after the capturing edge and drops right after the handshake.
            r_out_valid <= (w_next_state == c_ISSUE);
            if (w_clear)
                r_have_prev <= 1'b0;
            else if (w_done)
                r_have_prev <= 1'b1;
        end
    end

    assign bus.a_out     = {r_a, {PAD_W{1'b0}}};
    assign bus.b_out     = {r_b, {PAD_W{1'b0}}};
    assign bus.op_out    = r_op;
    assign bus.unsig_out = r_unsig;
    assign bus.out_valid = r_out_valid;
    assign state_dbg     = r_state;
    assign have_prev     = r_have_prev;

`ifdef OPERAND_ECHO_EN
    // ------------------------------------------------------------------
    // Display echo: live switch view while loading, A while issuing
    // ------------------------------------------------------------------
    logic [31:0] r_echo;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_echo <= '0;
        end else begin
            case (r_state)
                c_LOAD_A:  r_echo <= {SW[7:0], {PAD_W{1'b0}}};
                c_LOAD_B:  r_echo <= {SW[15:8], {PAD_W{1'b0}}};
                c_LOAD_OP: r_echo <= {29'b0, SW[2:0]};
                default:   r_echo <= {r_a, {PAD_W{1'b0}}};
            endcase
        end
    end

    assign echo_out = r_echo;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_operand_loader
//  Description : Scoreboard bench for alu_operand_loader. Stimulus pushes the
//                expected operand set before the press that issues it. A
//                monitor pops on each rising out_valid and checks the set on
//                every cycle that valid stays high.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_operand_loader;
    localparam int DEB = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [16:0] sw  = '0;
    logic [3:1]  key = 3'b111;
    logic [1:0]  state_dbg;
    logic        have_prev;
`ifdef OPERAND_ECHO_EN
    logic [31:0] echo_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    alu_operand_loader_if bus ();

    alu_operand_loader #(.DEBOUNCE_CYCLES(DEB), .PAD_W(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .SW        (sw),
        .KEY       (key),
        .bus       (bus),
`ifdef OPERAND_ECHO_EN
        .echo_out  (echo_out),
`endif
        .state_dbg (state_dbg),
        .have_prev (have_prev)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Scoreboard: {a, b, op, unsig}
    // ------------------------------------------------------------------
    logic [67:0] exp_q[$];
    logic [67:0] cur;
    logic        have_cur   = 1'b0;
    logic        prev_valid = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.out_valid && !prev_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    have_cur = 1'b0;
                    $display("FAIL unexpected_issue: got a=%h b=%h op=%0d u=%0b, nothing expected",
                             bus.a_out, bus.b_out, bus.op_out, bus.unsig_out);
                end else begin
                    cur      = exp_q.pop_front();
                    have_cur = 1'b1;
                end
            end
            if (bus.out_valid && have_cur) begin
                n_checks++;
                if ({bus.a_out, bus.b_out, bus.op_out, bus.unsig_out} !== cur) begin
                    n_fail++;
                    $display("FAIL operand_set: got a=%h b=%h op=%0d u=%0b, want a=%h b=%h op=%0d u=%0b",
                             bus.a_out, bus.b_out, bus.op_out, bus.unsig_out,
                             cur[67:36], cur[35:4], cur[3:1], cur[0]);
                end
            end
            prev_valid = bus.out_valid;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Hold the selected buttons low long enough to debounce, then release.
    task automatic press(input logic [3:1] m);
        key = ~m;
        repeat (DEB + 8) @(negedge clk);
        key = 3'b111;
        repeat (DEB + 8) @(negedge clk);
    endtask

    task automatic hold_key1(input int cyc, input logic lvl);
        key[1] = lvl;
        repeat (cyc) @(negedge clk);
    endtask

    initial begin
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_a", bus.a_out, 32'h0);
        check("rst_b", bus.b_out, 32'h0);
        check("rst_op", {29'b0, bus.op_out}, 32'h0);
        check("rst_unsig", {31'b0, bus.unsig_out}, 32'h0);
        check("rst_valid", {31'b0, bus.out_valid}, 32'h0);
        check("rst_state", {30'b0, state_dbg}, 32'h0);
        check("rst_have_prev", {31'b0, have_prev}, 32'h0);

        // Basic three-step load
        sw = 17'h0005A;
        press(3'b001);
        check("load_a_state", {30'b0, state_dbg}, 32'd1);
        sw = 17'h03C00;
        press(3'b001);
        check("load_b_state", {30'b0, state_dbg}, 32'd2);
        sw = 17'h10005;
        exp_q.push_back({32'h5A000000, 32'h3C000000, 3'd5, 1'b1});
        key = 3'b110;
        repeat (DEB + 3) @(negedge clk);
        check("issue_valid_early", {31'b0, bus.out_valid}, 32'd1);
        key = 3'b111;
        repeat (DEB + 8) @(negedge clk);
        check("issue_state", {30'b0, state_dbg}, 32'd3);

        // Backpressure with switches moving
        for (int i = 0; i < 10; i++) begin
            sw = 17'($urandom);
            @(negedge clk);
        end
        check("hold_valid", {31'b0, bus.out_valid}, 32'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("hs_valid", {31'b0, bus.out_valid}, 32'd0);
        check("hs_state", {30'b0, state_dbg}, 32'd0);
        check("hs_have_prev", {31'b0, have_prev}, 32'd1);

        // Load and reissue together in LOAD_A: load wins
        sw = 17'h00044;
        press(3'b101);
        check("both_state", {30'b0, state_dbg}, 32'd1);
        check("both_a", bus.a_out, 32'h44000000);

        // Bouncing KEY[1] in LOAD_B, then a clean long hold
        sw = 17'h02200;
        hold_key1(5, 1'b0);
        hold_key1(3, 1'b1);
        hold_key1(7, 1'b0);
        hold_key1(2, 1'b1);
        hold_key1(10, 1'b0);
        hold_key1(4, 1'b1);
        check("bounce_no_advance", {30'b0, state_dbg}, 32'd1);
        hold_key1(DEB + 3, 1'b0);
        hold_key1(DEB + 8, 1'b1);
        check("bounce_state", {30'b0, state_dbg}, 32'd2);
        check("bounce_b", bus.b_out, 32'h22000000);

        // Clear from LOAD_OP, then reissue must be ignored
        press(3'b010);
        check("clr_state", {30'b0, state_dbg}, 32'd0);
        check("clr_a", bus.a_out, 32'h0);
        check("clr_b", bus.b_out, 32'h0);
        check("clr_have_prev", {31'b0, have_prev}, 32'd0);
        press(3'b100);
        check("clr_reissue_state", {30'b0, state_dbg}, 32'd0);
        check("clr_reissue_valid", {31'b0, bus.out_valid}, 32'd0);
`ifdef OPERAND_ECHO_EN
        sw = 17'h000C3;
        repeat (2) @(negedge clk);
        check("echo_load_a", echo_out, 32'hC3000000);
`endif

        // Full transaction with ready held high (also high outside ISSUE)
        bus.out_ready = 1'b1;
        sw = 17'h000A5;
        press(3'b001);
        check("rdy_load_a_state", {30'b0, state_dbg}, 32'd1);
        sw = 17'h00F00;
        press(3'b001);
        sw = 17'h00003;
        exp_q.push_back({32'hA5000000, 32'h0F000000, 3'd3, 1'b0});
        press(3'b001);
        check("tx2_state", {30'b0, state_dbg}, 32'd0);
        check("tx2_have_prev", {31'b0, have_prev}, 32'd1);

        // Reissue of the previous operand set
        bus.out_ready = 1'b0;
        sw = 17'h1FFFF;
        exp_q.push_back({32'hA5000000, 32'h0F000000, 3'd3, 1'b0});
        press(3'b100);
        check("reissue_state", {30'b0, state_dbg}, 32'd3);
        check("reissue_valid", {31'b0, bus.out_valid}, 32'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("reissue_done_state", {30'b0, state_dbg}, 32'd0);

        // Reset in LOAD_B with KEY[1] held through it
        sw = 17'h00077;
        press(3'b001);
        check("pre_rst_state", {30'b0, state_dbg}, 32'd1);
        key[1] = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (DEB + 10) @(negedge clk);
        check("held_rst_state", {30'b0, state_dbg}, 32'd0);
        check("held_rst_a", bus.a_out, 32'h0);
        check("held_rst_have_prev", {31'b0, have_prev}, 32'd0);
        key[1] = 1'b1;
        repeat (DEB + 8) @(negedge clk);
        check("release_no_capture", {30'b0, state_dbg}, 32'd0);
        sw = 17'h00033;
        press(3'b001);
        check("repress_state", {30'b0, state_dbg}, 32'd1);
        check("repress_a", bus.a_out, 32'h33000000);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
